// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction-fetch controller.
//   - FSM state encodings: ST_IDLE, ST_REQ, ST_HOLD, ST_DROP
//   - NOP_INSTR: the instruction word used for an IF/ID bubble
//   - DEFAULT_RESET_PC: the default PC after reset
//   - pc_4adder: sequential PC increment, modulo 2^32
//   - align_word: forces an address onto a word boundary
package fetch_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;   // first cycle after reset
   localparam logic [1:0] ST_REQ  = 2'd1;   // request outstanding at pc_out
   localparam logic [1:0] ST_HOLD = 2'd2;   // fetched word parked while ID stalls
   localparam logic [1:0] ST_DROP = 2'd3;   // waiting to discard a stale response

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Sequential PC increment; the carry out is dropped, so the PC wraps.
   function automatic logic [31:0] pc_4adder(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // Clears the two byte-offset bits of a branch target.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_wdog.sv
// fetch_wdog: watchdog on the instruction-memory handshake.
// The counter advances on every cycle in which a request is up and is not
// acknowledged, and it clears on an acknowledged request. Once TIMEOUT_CYC
// such cycles have gone by in a row, fetch_err sets and holds until reset.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   req, ack   imem request and acknowledge as seen on the bus
//   fetch_err  sticky timeout flag
module fetch_wdog
   import fetch_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic ack,
   output logic fetch_err
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);

   logic [7:0] wait_cnt;

   // The wait counter saturates at LIMIT. The flag sets on the edge that
   // completes the LIMIT-th unanswered cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt  <= 8'd0;
         fetch_err <= 1'b0;
      end else if (req && ack) begin
         wait_cnt <= 8'd0;
      end else if (req) begin
         if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (wait_cnt >= (LIMIT - 8'd1)) begin
            fetch_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for the instruction-fetch stage.
// It owns the PC, drives a variable-latency imem through a req/ack handshake,
// applies branch redirects and ID stalls, and loads the IF/ID register.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   pcSrc, ex_mem_pc      redirect pulse and target from EX/MEM
//   id_stall              ID hazard stall; IF/ID must hold
//   imem_req, imem_addr   fetch request and word-aligned address
//   imem_ack, imem_rdata  response valid and instruction word
//   pc_out                current fetch PC
//   instr, pc_4           IF/ID instruction and PC+4
//   if_id_valid           IF/ID holds a real instruction
//   fetch_err             sticky imem timeout flag
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcSrc,
   input  logic [31:0] ex_mem_pc,
   input  logic        id_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instr,
   output logic [31:0] pc_4,
   output logic        if_id_valid,
   output logic        fetch_err
);

   logic [1:0]  state;
   logic [31:0] drop_addr;   // address of the request being discarded
   logic [31:0] buf_instr;   // word parked while ID stalls
   logic [31:0] buf_pc4;
   logic [31:0] redirect_pc;
   logic [31:0] next_seq_pc;

   assign redirect_pc = align_word(ex_mem_pc);
   assign next_seq_pc = pc_4adder(pc_out);

   // Redirects move pc_out to the target right away. While a stale request
   // is still outstanding (DROP), the bus keeps showing its original address.
   assign imem_req  = (state == ST_REQ) || (state == ST_DROP);
   assign imem_addr = (state == ST_DROP) ? drop_addr : pc_out;

   // Fetch sequencer: PC, IF/ID register, hold buffer and state transitions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         pc_out      <= RESET_PC;
         drop_addr   <= RESET_PC;
         buf_instr   <= NOP_INSTR;
         buf_pc4     <= 32'h0000_0000;
         instr       <= NOP_INSTR;
         pc_4        <= 32'h0000_0000;
         if_id_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_REQ;
               if (pcSrc) begin
                  pc_out      <= redirect_pc;
                  instr       <= NOP_INSTR;
                  if_id_valid <= 1'b0;
               end
            end
            ST_REQ: begin
               if (pcSrc) begin
                  pc_out      <= redirect_pc;
                  instr       <= NOP_INSTR;
                  if_id_valid <= 1'b0;
                  if (!imem_ack) begin
                     drop_addr <= pc_out;
                     state     <= ST_DROP;
                  end
               end else if (imem_ack) begin
                  if (id_stall) begin
                     buf_instr <= imem_rdata;
                     buf_pc4   <= next_seq_pc;
                     state     <= ST_HOLD;
                  end else begin
                     instr       <= imem_rdata;
                     pc_4        <= next_seq_pc;
                     if_id_valid <= 1'b1;
                     pc_out      <= next_seq_pc;
                  end
               end
            end
            ST_HOLD: begin
               if (pcSrc) begin
                  pc_out      <= redirect_pc;
                  instr       <= NOP_INSTR;
                  if_id_valid <= 1'b0;
                  state       <= ST_REQ;
               end else if (!id_stall) begin
                  instr       <= buf_instr;
                  pc_4        <= buf_pc4;
                  if_id_valid <= 1'b1;
                  pc_out      <= buf_pc4;
                  state       <= ST_REQ;
               end
            end
            ST_DROP: begin
               // The newest target wins. The stale response only ends DROP;
               // its data never reaches IF/ID.
               if (pcSrc) begin
                  pc_out      <= redirect_pc;
                  instr       <= NOP_INSTR;
                  if_id_valid <= 1'b0;
               end
               if (imem_ack) begin
                  state <= ST_REQ;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   fetch_wdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .req      (imem_req),
      .ack      (imem_ack),
      .fetch_err(fetch_err)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A transaction-level
// model predicts all outputs every cycle. Directed tasks cover the main
// scenarios and a randomized run covers everything else.
module tb_fetch_ctrl;

   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam int          TO  = 16;
   localparam logic [31:0] XK  = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcSrc;
   logic [31:0] ex_mem_pc;
   logic        id_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instr;
   logic [31:0] pc_4;
   logic        if_id_valid;
   logic        fetch_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RPC), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .pcSrc(pcSrc), .ex_mem_pc(ex_mem_pc),
      .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
      .instr(instr), .pc_4(pc_4), .if_id_valid(if_id_valid),
      .fetch_err(fetch_err)
   );

   logic [130:0] dut_vec;
   assign dut_vec = {imem_req, imem_addr, pc_out, instr, pc_4, if_id_valid, fetch_err};

   localparam logic [130:0] RESET_VEC = {1'b0, RPC, RPC, 32'h0, 32'h0, 1'b0, 1'b0};

   // Reference model: tracks whether a fetch is in flight, whether its answer
   // is stale, and a queue of words parked behind an ID stall.
   bit          m_started, m_req_on, m_discard, m_valid, m_err;
   logic [31:0] m_pc, m_req_addr, m_instr, m_pc4;
   int          m_wait;
   logic [63:0] m_held[$];

   function automatic logic [130:0] exp_vec();
      return {1'(m_req_on), (m_req_on ? m_req_addr : m_pc), m_pc, m_instr, m_pc4,
              1'(m_valid), 1'(m_err)};
   endfunction

   task automatic model_reset();
      m_started = 0; m_req_on = 0; m_discard = 0; m_valid = 0; m_err = 0;
      m_pc = RPC; m_req_addr = RPC; m_instr = 32'h0; m_pc4 = 32'h0;
      m_wait = 0; m_held.delete();
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      bit          got;
      tgt = ex_mem_pc & ~32'h3;
      got = m_req_on && imem_ack;
      if (m_req_on) begin
         if (imem_ack) m_wait = 0;
         else begin
            m_wait++;
            if (m_wait >= TO) m_err = 1;
         end
      end
      if (!m_started) begin
         m_started = 1;
         if (pcSrc) begin m_pc = tgt; m_instr = 32'h0; m_valid = 0; end
         m_req_on = 1; m_req_addr = m_pc;
      end else if (pcSrc) begin
         m_pc = tgt; m_instr = 32'h0; m_valid = 0; m_held.delete();
         if (m_req_on && !imem_ack) m_discard = 1;
         else begin m_req_on = 1; m_discard = 0; m_req_addr = m_pc; end
      end else if (got) begin
         if (m_discard) begin
            m_discard = 0; m_req_addr = m_pc;
         end else if (id_stall) begin
            m_held.push_back({imem_rdata, m_pc + 32'd4});
            m_req_on = 0;
         end else begin
            m_instr = imem_rdata; m_pc = m_pc + 32'd4; m_pc4 = m_pc;
            m_valid = 1; m_req_addr = m_pc;
         end
      end else if (m_held.size() > 0 && !id_stall) begin
         {m_instr, m_pc4} = m_held.pop_front();
         m_valid = 1; m_pc = m_pc + 32'd4; m_req_on = 1; m_req_addr = m_pc;
      end
   endtask

   // One clock: drive the inputs, let the edge happen, advance the model,
   // and come back at the falling edge for sampling.
   task automatic tick(input bit p, input logic [31:0] t, input bit s, input bit a);
      pcSrc = p; ex_mem_pc = t; id_stall = s; imem_ack = a;
      imem_rdata = (m_req_on ? m_req_addr : m_pc) ^ XK;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; pcSrc = 0; ex_mem_pc = 32'h0; id_stall = 0; imem_ack = 0;
      imem_rdata = 32'h0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (dut_vec !== RESET_VEC) begin
         errors++; $display("FAIL reset: got %h want %h", dut_vec, RESET_VEC);
      end
   endtask

   task automatic test_stream();
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         tick(0, 32'h0, 0, 1);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL stream %0d: got %h want %h", i, dut_vec, exp_vec());
         end
         checks++;
         if (imem_addr !== 32'(4 * i) ||
             (i > 0 && (pc_4 !== 32'(4 * i) || instr !== (32'(4 * (i - 1)) ^ XK)))) begin
            errors++;
            $display("FAIL stream_seq %0d: got addr %h pc_4 %h instr %h want addr %h",
                     i, imem_addr, pc_4, instr, 32'(4 * i));
         end
      end
   endtask

   task automatic test_latency3();
      int  wc;
      bit  a;
      apply_reset();
      wc = 0;
      for (int i = 0; i < 30; i++) begin
         a = m_req_on && (wc == 2);
         tick(0, 32'h0, 0, a);
         if (a || !m_req_on) wc = 0; else wc++;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL latency3 %0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_stall();
      apply_reset();
      for (int g = 0; g < 10 && !(m_req_on && m_req_addr == 32'h8); g++) tick(0, 32'h0, 0, 1);
      tick(0, 32'h0, 1, 1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dut_vec !== exp_vec() || imem_req !== 1'b0 || pc_4 !== 32'h8) begin
            errors++; $display("FAIL stall_hold %0d: got %h want %h", k, dut_vec, exp_vec());
         end
         if (k < 3) tick(0, 32'h0, 1, 0);
      end
      tick(0, 32'h0, 0, 0);
      checks++;
      if (instr !== (32'h8 ^ XK) || pc_4 !== 32'hC || if_id_valid !== 1'b1 ||
          imem_req !== 1'b1 || imem_addr !== 32'hC || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL stall_release: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_redirect();
      apply_reset();
      for (int g = 0; g < 10 && !(m_req_on && m_req_addr == 32'h10); g++) tick(0, 32'h0, 0, 1);
      tick(1, 32'h40, 0, 0);
      checks++;
      if (if_id_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== 32'h10 ||
          imem_req !== 1'b1 || pc_out !== 32'h40 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL redirect_drop: got %h want %h", dut_vec, exp_vec());
      end
      tick(1, 32'h80, 0, 0);
      tick(0, 32'h0, 0, 1);
      checks++;
      if (imem_addr !== 32'h80 || imem_req !== 1'b1 || if_id_valid !== 1'b0 ||
          dut_vec !== exp_vec()) begin
         errors++; $display("FAIL redirect_retarget: got %h want %h", dut_vec, exp_vec());
      end
      tick(0, 32'h0, 0, 1);
      checks++;
      if (instr !== (32'h80 ^ XK) || pc_4 !== 32'h84 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL redirect_fetch: got %h want %h", dut_vec, exp_vec());
      end
      tick(1, 32'h0000_0103, 0, 1);
      checks++;
      if (imem_addr !== 32'h100 || pc_out !== 32'h100 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL redirect_align: got %h want %h", dut_vec, exp_vec());
      end
      tick(1, 32'hFFFF_FFFE, 0, 1);
      tick(0, 32'h0, 0, 1);
      checks++;
      if (pc_out !== 32'h0 || pc_4 !== 32'h0 || instr !== (32'hFFFF_FFFC ^ XK) ||
          dut_vec !== exp_vec()) begin
         errors++; $display("FAIL pc_wrap: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_flush_stall();
      apply_reset();
      repeat (4) tick(0, 32'h0, 0, 1);
      tick(1, 32'h200, 1, 1);
      checks++;
      if (if_id_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== 32'h200 ||
          dut_vec !== exp_vec()) begin
         errors++; $display("FAIL flush_stall: got %h want %h", dut_vec, exp_vec());
      end
      tick(0, 32'h0, 0, 1);
      tick(0, 32'h0, 1, 1);
      tick(1, 32'h300, 1, 0);
      checks++;
      if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300 ||
          dut_vec !== exp_vec()) begin
         errors++; $display("FAIL flush_hold: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      tick(0, 32'h0, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         tick(0, 32'h0, 0, 0);
         checks++;
         if (fetch_err !== 1'(i >= TO) || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL timeout %0d: got err %b want %b", i, fetch_err, i >= TO);
         end
      end
      tick(0, 32'h0, 0, 1);
      tick(0, 32'h0, 0, 1);
      checks++;
      if (fetch_err !== 1'b1 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL timeout_sticky: got %h want %h", dut_vec, exp_vec());
      end
      #1 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== RESET_VEC) begin
         errors++; $display("FAIL timeout_reset: got %h want %h", dut_vec, RESET_VEC);
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (5) tick(0, 32'h0, 0, 0);
      #1 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== RESET_VEC) begin
         errors++; $display("FAIL async_wait: got %h want %h", dut_vec, RESET_VEC);
      end
      @(negedge clk) rst = 1'b0;
      repeat (3) tick(0, 32'h0, 0, 1);
      tick(0, 32'h0, 1, 1);
      #1 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== RESET_VEC) begin
         errors++; $display("FAIL async_hold: got %h want %h", dut_vec, RESET_VEC);
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_random();
      bit          p, s, a;
      logic [31:0] t;
      apply_reset();
      for (int i = 0; i < 800; i++) begin
         p = ($urandom % 16) == 0;
         t = ($urandom % 8 == 0) ? 32'hFFFF_FFF8 : $urandom;
         s = ($urandom % 3) == 0;
         a = ($urandom % 5) < 2;
         tick(p, t, s, a);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL random %0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1; pcSrc = 0; ex_mem_pc = 32'h0; id_stall = 0; imem_ack = 0;
      imem_rdata = 32'h0;
      model_reset();
      test_reset();
      test_stream();
      test_latency3();
      test_stall();
      test_redirect();
      test_flush_stall();
      test_timeout();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL sim_timeout: bench did not complete within time limit");
      $fatal(1);
   end

endmodule
